// File: rtl/axi_stream_insert_header_q.sv
// rtl/axi_stream_insert_header_q.sv - Prepends a queued byte-granular header to each AXI-Stream packet
// Headers wait in a small FIFO; each packet is re-aligned through a residual byte register.
module axi_stream_insert_header_q #(
  parameter int DATA_WD   = 32,
  parameter int HDR_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  output logic                       ready_in,
  input  logic [DATA_WD-1:0]         data_in,
  input  logic [DATA_WD/8-1:0]       keep_in,
  input  logic                       last_in,
  input  logic                       valid_insert,
  output logic                       ready_insert,
  input  logic [DATA_WD-1:0]         data_insert,
  input  logic [DATA_WD/8-1:0]       keep_insert,
  input  logic [$clog2(DATA_WD/8):0] byte_insert_cnt,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [DATA_WD-1:0]         data_out,
  output logic [DATA_WD/8-1:0]       keep_out,
  output logic                       last_out
);
  localparam int N      = DATA_WD / 8;
  localparam int CNT_WD = $clog2(N) + 1;
  localparam int AW     = $clog2(HDR_DEPTH);
  localparam int SH_WD  = CNT_WD + 3;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  state_t state, state_n;

  logic [DATA_WD-1:0] fifo_data [HDR_DEPTH];
  logic [CNT_WD-1:0]  fifo_cnt  [HDR_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               fifo_empty, fifo_full, push, pop;

  logic [DATA_WD-1:0] residual, residual_n;
  logic [CNT_WD-1:0]  h_reg, h_n, flush_cnt, flush_n;
  logic               valid_n, last_n;
  logic [DATA_WD-1:0] data_n, beat;
  logic [N-1:0]       keep_n;
  logic [CNT_WD-1:0]  k_cnt;
  logic [CNT_WD:0]    total;
  logic [SH_WD-1:0]   sh_h, sh_nh;
  logic               adv;
  logic               unused_keep_insert;

  assign unused_keep_insert = ^keep_insert;
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ready_insert = !fifo_full;
  assign push         = valid_insert && !fifo_full;
  assign adv          = !valid_out || ready_out;
  assign ready_in     = (state == STREAM) && adv;
  assign sh_h         = {h_reg, 3'b000};
  assign sh_nh        = {CNT_WD'(N) - h_reg, 3'b000};
  assign total        = {1'b0, h_reg} + {1'b0, k_cnt};

  function automatic logic [DATA_WD-1:0] low_bytes(input logic [DATA_WD-1:0] d,
                                                   input logic [CNT_WD-1:0] h);
    low_bytes = d & ~({DATA_WD{1'b1}} << {h, 3'b000});
  endfunction

  function automatic logic [N-1:0] top_lanes(input logic [CNT_WD:0] m);
    top_lanes = ~({N{1'b1}} >> m);
  endfunction

  function automatic logic [DATA_WD-1:0] lane_mask(input logic [N-1:0] k);
    for (int j = 0; j < N; j++) lane_mask[8*j +: 8] = {8{k[j]}};
  endfunction

  always_comb begin
    k_cnt = '0;
    for (int j = 0; j < N; j++) k_cnt = k_cnt + CNT_WD'(keep_in[j]);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr[AW-1:0]] <= data_insert;
      fifo_cnt[wr_ptr[AW-1:0]]  <= byte_insert_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Residual bytes sit right-aligned; they lead the next beat, followed by the top N-H bytes of input.
  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    residual_n = residual;
    h_n        = h_reg;
    flush_n    = flush_cnt;
    valid_n    = adv ? 1'b0 : valid_out;
    data_n     = data_out;
    keep_n     = keep_out;
    last_n     = last_out;
    beat       = (residual << sh_nh) | (data_in >> sh_h);
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          h_n        = fifo_cnt[rd_ptr[AW-1:0]];
          residual_n = low_bytes(fifo_data[rd_ptr[AW-1:0]], fifo_cnt[rd_ptr[AW-1:0]]);
          state_n    = STREAM;
        end
      end
      STREAM: begin
        if (valid_in && adv) begin
          valid_n    = 1'b1;
          last_n     = 1'b0;
          keep_n     = '1;
          residual_n = low_bytes(data_in, h_reg);
          if (last_in) begin
            if (total <= (CNT_WD+1)'(N)) begin
              keep_n     = top_lanes(total);
              last_n     = 1'b1;
              residual_n = '0;
              state_n    = IDLE;
            end else begin
              flush_n = CNT_WD'(total - (CNT_WD+1)'(N));
              state_n = FLUSH;
            end
          end
          data_n = beat & lane_mask(keep_n);
        end
      end
      FLUSH: begin
        if (adv) begin
          valid_n    = 1'b1;
          last_n     = 1'b1;
          keep_n     = top_lanes({1'b0, flush_cnt});
          data_n     = (residual << sh_nh) & lane_mask(keep_n);
          residual_n = '0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      residual  <= '0;
      h_reg     <= '0;
      flush_cnt <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      state     <= state_n;
      residual  <= residual_n;
      h_reg     <= h_n;
      flush_cnt <= flush_n;
      valid_out <= valid_n;
      data_out  <= data_n;
      keep_out  <= keep_n;
      last_out  <= last_n;
    end
  end
endmodule

// File: tb/tb_axi_stream_insert_header_q.sv
// tb/tb_axi_stream_insert_header_q.sv - Table-driven and scoreboard bench for axi_stream_insert_header_q
module tb_axi_stream_insert_header_q;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        valid_in, ready_in, last_in, valid_insert, ready_insert;
  logic        valid_out, ready_out, last_out;
  logic [31:0] data_in, data_insert, data_out;
  logic [3:0]  keep_in, keep_insert, keep_out;
  logic [2:0]  byte_insert_cnt;

  logic        vin64, rin64, lin64, vins64, rins64, vout64, rout64, lout64;
  logic [63:0] din64, dins64, dout64;
  logic [7:0]  kin64, kins64, kout64;
  logic [3:0]  cnt64;

  axi_stream_insert_header_q #(.DATA_WD(32), .HDR_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .valid_insert(valid_insert), .ready_insert(ready_insert), .data_insert(data_insert),
    .keep_insert(keep_insert), .byte_insert_cnt(byte_insert_cnt),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out)
  );

  axi_stream_insert_header_q #(.DATA_WD(64), .HDR_DEPTH(2)) dut64 (
    .clk(clk), .rst(rst),
    .valid_in(vin64), .ready_in(rin64), .data_in(din64), .keep_in(kin64), .last_in(lin64),
    .valid_insert(vins64), .ready_insert(rins64), .data_insert(dins64),
    .keep_insert(kins64), .byte_insert_cnt(cnt64),
    .valid_out(vout64), .ready_out(rout64), .data_out(dout64), .keep_out(kout64), .last_out(lout64)
  );

  typedef struct { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
  typedef struct { logic [31:0] d; int h; } hdr_t;
  typedef struct {
    logic [31:0] hdr; int h; int nb;
    logic [31:0] pd [3]; logic [3:0] pk [3];
    int ne; logic [31:0] ed [3]; logic [3:0] ek [3];
  } vec_t;

  beat_t exp_q[$];
  hdr_t  hq[$];
  vec_t  vt[6];
  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;
  bit    rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte-stream reference: header bytes then payload bytes, re-chunked into N-byte beats.
  task automatic model_push(input logic [31:0] hd, input int h, input logic [31:0] pb[$], input int k);
    logic [7:0] bytes[$];
    beat_t e;
    int n, nl;
    for (int i = 0; i < h; i++) bytes.push_back(hd[8*(h-1-i) +: 8]);
    for (int b = 0; b < pb.size(); b++) begin
      nl = (b == pb.size() - 1) ? k : 4;
      for (int l = 0; l < nl; l++) bytes.push_back(pb[b][31-8*l -: 8]);
    end
    while (bytes.size() > 0) begin
      e.d = '0;
      e.k = '0;
      n = (bytes.size() < 4) ? bytes.size() : 4;
      for (int l = 0; l < n; l++) begin
        e.d[31-8*l -: 8] = bytes.pop_front();
        e.k[3-l] = 1'b1;
      end
      e.l = (bytes.size() == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_hdr(input logic [31:0] d, input int h);
    int t = 0;
    valid_insert = 1'b1;
    data_insert = d;
    byte_insert_cnt = 3'(h);
    keep_insert = 4'((32'h1 << h) - 1);
    @(negedge clk);
    while (!ready_insert && t < 500) begin @(negedge clk); t++; end
    if (!ready_insert) begin
      checks++; errors++;
      $display("FAIL hdr_timeout: got ready_insert=0 expected 1 within 500 cycles");
    end
    @(posedge clk); #1;
    valid_insert = 1'b0;
    hq.push_back('{d, h});
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t = 0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    @(negedge clk);
    while (!ready_in && t < 500) begin @(negedge clk); t++; end
    if (!ready_in) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got ready_in=0 expected 1 within 500 cycles");
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic send_payload(input logic [31:0] pd[$], input logic [3:0] pk[$], input bit use_model);
    hdr_t hh;
    if (hq.size() == 0) begin
      checks++; errors++;
      $display("FAIL no_header: got empty header model expected a queued header");
      return;
    end
    hh = hq.pop_front();
    if (use_model) model_push(hh.d, hh.h, pd, $countones(pk[pk.size()-1]));
    for (int b = 0; b < pd.size(); b++) drive_beat(pd[b], pk[b], b == pd.size() - 1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats outstanding expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk); #1;
      ready_out = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  beat_t       mb;
  logic        stalled = 1'b0;
  logic [31:0] s_d;
  logic [3:0]  s_k;
  logic        s_l;
  initial forever begin
    @(negedge clk);
    if (rst || !mon_en) stalled = 1'b0;
    else begin
      if (stalled) begin
        checks++;
        if (!valid_out || data_out !== s_d || keep_out !== s_k || last_out !== s_l) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%h k=%b l=%0b expected v=1 d=%h k=%b l=%0b",
                   valid_out, data_out, keep_out, last_out, s_d, s_k, s_l);
        end
      end
      if (valid_out && ready_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got d=%h k=%b l=%0b expected no beat", data_out, keep_out, last_out);
        end else begin
          mb = exp_q.pop_front();
          if (data_out !== mb.d || keep_out !== mb.k || last_out !== mb.l) begin
            errors++;
            $display("FAIL out_beat: got d=%h k=%b l=%0b expected d=%h k=%b l=%0b",
                     data_out, keep_out, last_out, mb.d, mb.k, mb.l);
          end
        end
      end
      stalled = valid_out && !ready_out;
      s_d = data_out; s_k = keep_out; s_l = last_out;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  logic [31:0] pq[$];
  logic [3:0]  kq[$];
  beat_t       eb;
  int          got;
  logic        acc;
  logic [63:0] e64d [2];
  logic [8:0]  e64c [2];

  initial begin
    rst = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;
    vin64 = 1'b0; din64 = '0; kin64 = '0; lin64 = 1'b0;
    vins64 = 1'b0; dins64 = '0; kins64 = '0; cnt64 = '0; rout64 = 1'b1;

    vt[0] = '{32'h0000AABB, 2, 2, '{32'h11223344, 32'h55667788, 32'h0}, '{4'b0000, 4'b1111, 4'h0},
              3, '{32'hAABB1122, 32'h33445566, 32'h77880000}, '{4'b1111, 4'b1111, 4'b1100}};
    vt[1] = '{32'h00CCDDEE, 3, 1, '{32'h99000000, 32'h0, 32'h0}, '{4'b1000, 4'h0, 4'h0},
              1, '{32'hCCDDEE99, 32'h0, 32'h0}, '{4'b1111, 4'h0, 4'h0}};
    vt[2] = '{32'h00000000, 0, 2, '{32'hDEADBEEF, 32'h01020304, 32'h0}, '{4'b0101, 4'b1110, 4'h0},
              2, '{32'hDEADBEEF, 32'h01020300, 32'h0}, '{4'b1111, 4'b1110, 4'h0}};
    vt[3] = '{32'h12345678, 4, 1, '{32'hA1A2A3A4, 32'h0, 32'h0}, '{4'b1100, 4'h0, 4'h0},
              2, '{32'h12345678, 32'hA1A20000, 32'h0}, '{4'b1111, 4'b1100, 4'h0}};
    vt[4] = '{32'hFFFFFF5A, 1, 2, '{32'h10203040, 32'h50607080, 32'h0}, '{4'b0011, 4'b1110, 4'h0},
              2, '{32'h5A102030, 32'h40506070, 32'h0}, '{4'b1111, 4'b1111, 4'h0}};
    vt[5] = '{32'h00C1C2C3, 3, 1, '{32'hD1D2D3D4, 32'h0, 32'h0}, '{4'b1111, 4'h0, 4'h0},
              2, '{32'hC1C2C3D1, 32'hD2D3D400, 32'h0}, '{4'b1111, 4'b1110, 4'h0}};
    e64d[0] = 64'h0102030405060708; e64c[0] = {8'hFF, 1'b0};
    e64d[1] = 64'h1112131415161718; e64c[1] = {8'hFF, 1'b1};

    repeat (3) @(posedge clk); #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_keep_last", {data_out, keep_out, last_out}, 0);
    chk("rst_ready_in", ready_in, 0);
    chk("rst_ready_insert", ready_insert, 1);
    chk("rst_valid_out64", vout64, 0);
    @(negedge clk); rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vt[i].ne; j++) begin
        eb.d = vt[i].ed[j]; eb.k = vt[i].ek[j]; eb.l = (j == vt[i].ne - 1);
        exp_q.push_back(eb);
      end
      pq.delete(); kq.delete();
      for (int j = 0; j < vt[i].nb; j++) begin pq.push_back(vt[i].pd[j]); kq.push_back(vt[i].pk[j]); end
      push_hdr(vt[i].hdr, vt[i].h);
      send_payload(pq, kq, 1'b0);
      drain();
    end

    push_hdr(32'h000000A1, 1);
    push_hdr(32'h0000B1B2, 2);
    push_hdr(32'h00C1C2C3, 3);
    push_hdr(32'hD1D2D3D4, 0);
    push_hdr(32'h0000E1E2, 2);
    @(negedge clk);
    chk("ready_insert_full", ready_insert, 0);
    repeat (3) @(negedge clk);
    chk("ready_insert_hold", ready_insert, 0);
    @(posedge clk); #1;
    for (int p = 0; p < 5; p++) begin
      pq.delete(); kq.delete();
      pq.push_back(32'h10111213 + 32'h10101010 * p);
      kq.push_back((p == 1) ? 4'b1100 : (p == 2) ? 4'b1110 : (p == 4) ? 4'b1000 : 4'b1111);
      send_payload(pq, kq, 1'b1);
    end
    drain();
    chk("ready_insert_free", ready_insert, 1);

    rnd_rdy = 1'b1;
    for (int p = 0; p < 200; p++) begin
      int h, nb, k;
      logic [31:0] hd;
      logic [3:0] lk;
      h = $urandom_range(0, 4); nb = $urandom_range(1, 4); k = $urandom_range(1, 4);
      hd = $urandom;
      lk = ~(4'hF >> k);
      pq.delete(); kq.delete();
      for (int b = 0; b < nb; b++) begin
        pq.push_back($urandom);
        kq.push_back((b == nb - 1) ? lk : 4'($urandom));
      end
      push_hdr(hd, h);
      send_payload(pq, kq, 1'b1);
    end
    drain();

    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk); #1;
    push_hdr(32'h0000A1A2, 2);
    push_hdr(32'h000000EE, 1);
    mon_en = 1'b0;
    drive_beat(32'h01010101, 4'hF, 1'b0);
    drive_beat(32'h02020202, 4'hF, 1'b0);
    valid_in = 1'b1; data_in = 32'h03030303; keep_in = 4'hF; last_in = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_data_keep_last", {data_out, keep_out, last_out}, 0);
    chk("midrst_ready_in", ready_in, 0);
    chk("midrst_ready_insert", ready_insert, 1);
    valid_in = 1'b0;
    exp_q.delete(); hq.delete();
    valid_insert = 1'b1; data_insert = 32'h00C0C1C2; keep_insert = 4'b0111; byte_insert_cnt = 3'd3;
    @(negedge clk); rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    valid_insert = 1'b0;
    hq.push_back('{32'h00C0C1C2, 3});
    @(negedge clk); @(negedge clk);
    chk("first_hdr_after_rst", ready_in, 1);
    pq.delete(); kq.delete();
    pq.push_back(32'h0A0B0C0D); kq.push_back(4'hF);
    pq.push_back(32'h0E0F1011); kq.push_back(4'b1110);
    eb.d = 32'hC0C1C20A; eb.k = 4'hF;    eb.l = 1'b0; exp_q.push_back(eb);
    eb.d = 32'h0B0C0D0E; eb.k = 4'hF;    eb.l = 1'b0; exp_q.push_back(eb);
    eb.d = 32'h0F100000; eb.k = 4'b1100; eb.l = 1'b1; exp_q.push_back(eb);
    @(posedge clk); #1;
    send_payload(pq, kq, 1'b0);
    drain();

    vins64 = 1'b1; dins64 = 64'h0102030405060708; kins64 = 8'hFF; cnt64 = 4'd8;
    @(negedge clk);
    chk("ready_insert64", rins64, 1);
    @(posedge clk); #1;
    vins64 = 1'b0;
    vin64 = 1'b1; din64 = 64'h1112131415161718; kin64 = 8'hFF; lin64 = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(negedge clk);
      acc = vin64 && rin64;
      if (vout64) begin
        chk("w64_data", dout64, e64d[got]);
        chk("w64_keep_last", {kout64, lout64}, e64c[got]);
        got++;
      end
      @(posedge clk); #1;
      if (acc) vin64 = 1'b0;
    end
    chk("w64_beats", got, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
